board_pixel_mapper: RTL

//  Generates 640x480@60 VGA timing from a pixel-clock enable and maps each

---
 rtl/board_pixel_mapper.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/board_pixel_mapper.sv
// ---------------------------------------------------------------------------
// board_pixel_mapper
//   Generates VGA raster timing from a pixel-clock enable and maps every
//   visible pixel onto a 4x4 game board. The output value (0..12) is the tile
//   index used by the downstream colour lookup; 12 means background/grid.
//   Syncs, blank and coordinates go through the same two-stage pipeline so
//   they stay aligned with the value. The board is captured once per frame
//   (on the frame-wrap tick) so tiles never tear mid-frame.
//
// Ports
//   clk_i      system clock
//   rst_n_i    synchronous reset, active-low
//   pix_en_i   pixel-clock enable; all state holds while low
//   board_i    16 x 4-bit tile values, cell i = row*4+col at [4i+3:4i]
//   value_o    tile value for the colour lookup (0..12)
//   hsync_o    horizontal sync, active-low
//   vsync_o    vertical sync, active-low
//   blank_n_o  1 = visible pixel
//   px_x_o     x coordinate aligned with value_o
//   px_y_o     y coordinate aligned with value_o
// ---------------------------------------------------------------------------
module board_pixel_mapper #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned BOARD_X0 = 80,
  parameter int unsigned BOARD_Y0 = 0,
  parameter int unsigned CELL     = 120,
  parameter int unsigned LINE     = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               pix_en_i,
  input  logic [63:0]        board_i,
  output logic signed [31:0] value_o,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               blank_n_o,
  output logic [9:0]         px_x_o,
  output logic [9:0]         px_y_o
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LEN    = 10'(H_SYNC);
  localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LEN    = 10'(V_SYNC);
  localparam logic [9:0] X0        = 10'(BOARD_X0);
  localparam logic [9:0] Y0        = 10'(BOARD_Y0);
  localparam logic [9:0] SPAN      = 10'(4 * CELL);
  localparam logic [9:0] CELL_LAST = 10'(CELL - 1);
  localparam logic [9:0] LINE_W    = 10'(LINE);
  localparam logic [3:0] BG        = 4'd12;

  // -------------------------------------------------------------------------
  // Stage 0: raster counters, cell trackers, board snapshot
  // -------------------------------------------------------------------------
  logic [9:0]       h_q, h_d, v_q, v_d;
  logic [9:0]       offx_q, offx_d, offy_q, offy_d;
  logic [2:0]       col_q, col_d, row_q, row_d;
  logic [15:0][3:0] board_q, board_d;
  logic             h_wrap, v_wrap;

  assign h_wrap = (h_q == H_LAST);
  assign v_wrap = (v_q == V_LAST);

  always_comb begin
    h_d     = h_q;
    v_d     = v_q;
    offx_d  = offx_q;
    col_d   = col_q;
    offy_d  = offy_q;
    row_d   = row_q;
    board_d = board_q;
    if (pix_en_i) begin
      h_d = h_wrap ? '0 : h_q + 10'd1;
      if (h_wrap) v_d = v_wrap ? '0 : v_q + 10'd1;

      // Column tracker follows h_d so it always describes the counter it
      // sits next to. It realigns at the board's left edge every line; the
      // values it holds outside the board are never used.
      if (h_d == X0) begin
        offx_d = '0;
        col_d  = '0;
      end else if (offx_q == CELL_LAST) begin
        offx_d = '0;
        col_d  = col_q + 3'd1;
      end else begin
        offx_d = offx_q + 10'd1;
      end

      // Row tracker steps once per line, realigning at the board's top row.
      if (h_wrap) begin
        if (v_d == Y0) begin
          offy_d = '0;
          row_d  = '0;
        end else if (offy_q == CELL_LAST) begin
          offy_d = '0;
          row_d  = row_q + 3'd1;
        end else begin
          offy_d = offy_q + 10'd1;
        end
      end

      // Frame-wrap tick: take whatever board is presented on this tick.
      if (h_wrap && v_wrap) board_d = board_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      h_q     <= '0;
      v_q     <= '0;
      offx_q  <= '0;
      col_q   <= '0;
      offy_q  <= '0;
      row_q   <= '0;
      board_q <= '0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      offx_q  <= offx_d;
      col_q   <= col_d;
      offy_q  <= offy_d;
      row_q   <= row_d;
      board_q <= board_d;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 1: region decode of the current counter state
  // -------------------------------------------------------------------------
  // Window tests use unsigned offset-from-start compares; positions before
  // the start wrap to large values and fall outside the window.
  logic [9:0] h_rel, v_rel, hs_rel, vs_rel;
  logic       inb1_d, line1_d, act1_d, hs1_d, vs1_d;
  logic [3:0] cell1_d;

  assign h_rel  = h_q - X0;
  assign v_rel  = v_q - Y0;
  assign hs_rel = h_q - HS_START;
  assign vs_rel = v_q - VS_START;

  always_comb begin
    inb1_d  = (h_rel < SPAN) && (v_rel < SPAN);
    line1_d = (offx_q < LINE_W) || (offy_q < LINE_W);
    act1_d  = (h_q < H_ACT) && (v_q < V_ACT);
    hs1_d   = !(hs_rel < HS_LEN);
    vs1_d   = !(vs_rel < VS_LEN);
    cell1_d = {row_q[1:0], col_q[1:0]};
  end

  logic       inb1_q, line1_q, act1_q, hs1_q, vs1_q;
  logic [3:0] cell1_q;
  logic [9:0] h1_q, v1_q;

  // Stage 1 resets to "idle" (blank, syncs deasserted) so the first
  // post-reset output matches the reset output.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      inb1_q  <= 1'b0;
      line1_q <= 1'b0;
      act1_q  <= 1'b0;
      hs1_q   <= 1'b1;
      vs1_q   <= 1'b1;
      cell1_q <= '0;
      h1_q    <= '0;
      v1_q    <= '0;
    end else if (pix_en_i) begin
      inb1_q  <= inb1_d;
      line1_q <= line1_d;
      act1_q  <= act1_d;
      hs1_q   <= hs1_d;
      vs1_q   <= vs1_d;
      cell1_q <= cell1_d;
      h1_q    <= h_q;
      v1_q    <= v_q;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: tile lookup and output registers
  // -------------------------------------------------------------------------
  // Tile codes 13..15 have no colour entry; show them as background.
  logic [15:0][3:0] tile_c;

  for (genvar i = 0; i < 16; i++) begin : g_clamp
    assign tile_c[i] = (board_q[i] > BG) ? BG : board_q[i];
  end

  logic [3:0] val2_d, val2_q;
  logic       hs2_q, vs2_q, bn2_q;
  logic [9:0] x2_q, y2_q;

  assign val2_d = (!act1_q || !inb1_q || line1_q) ? BG : tile_c[cell1_q];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      val2_q <= BG;
      hs2_q  <= 1'b1;
      vs2_q  <= 1'b1;
      bn2_q  <= 1'b0;
      x2_q   <= '0;
      y2_q   <= '0;
    end else if (pix_en_i) begin
      val2_q <= val2_d;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
      bn2_q  <= act1_q;
      x2_q   <= h1_q;
      y2_q   <= v1_q;
    end
  end

  assign value_o   = signed'({28'd0, val2_q});
  assign hsync_o   = hs2_q;
  assign vsync_o   = vs2_q;
  assign blank_n_o = bn2_q;
  assign px_x_o    = x2_q;
  assign px_y_o    = y2_q;

endmodule
